// File: rtl/puf_key_extract.sv
// PUF key extractor: steps the PUF through four 2-bit challenges, lets each
// one settle, majority-votes NUM_SAMPLES 8-bit responses into one key byte
// per challenge and flags bits whose samples did not all agree.
module puf_key_extract #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned NUM_SAMPLES   = 7,
  parameter int unsigned MAX_UNSTABLE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  puf_response,
  output logic        puf_enable,
  output logic [1:0]  puf_challenge,
  output logic        busy,
  output logic [31:0] key,
  output logic [31:0] unstable_mask,
  output logic        key_valid,
  output logic        key_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_chal;
  logic [7:0]  r_cnt;
  logic [3:0]  r_ones [0:7];
  logic        r_enable;
  logic        r_busy;
  logic [31:0] r_key;
  logic [31:0] r_mask;
  logic        r_valid;

  logic [7:0]  w_keyByte;
  logic [7:0]  w_unstableByte;
  logic [5:0]  w_popCount;

  // Majority and disagreement of the accumulated ones counters for the current challenge.
  always_comb begin
    w_keyByte      = '0;
    w_unstableByte = '0;
    for (int i = 0; i < 8; i++) begin
      w_keyByte[i]      = (r_ones[i] > 4'(NUM_SAMPLES / 2));
      w_unstableByte[i] = (r_ones[i] != 4'd0) && (r_ones[i] != 4'(NUM_SAMPLES));
    end
  end

  // Count unstable bits so the error flag can follow the mask without a register stage.
  always_comb begin
    w_popCount = '0;
    for (int i = 0; i < 32; i++) begin
      w_popCount = w_popCount + 6'(r_mask[i]);
    end
  end

  // Sequencer: settle, sample, commit per challenge; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_chal   <= 2'd0;
      r_cnt    <= 8'd0;
      for (int i = 0; i < 8; i++) r_ones[i] <= 4'd0;
      r_enable <= 1'b0;
      r_busy   <= 1'b0;
      r_key    <= 32'd0;
      r_mask   <= 32'd0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state  <= S_SETTLE;
            r_chal   <= 2'd0;
            r_cnt    <= 8'd0;
            for (int i = 0; i < 8; i++) r_ones[i] <= 4'd0;
            r_enable <= 1'b1;
            r_busy   <= 1'b1;
            r_key    <= 32'd0;
            r_mask   <= 32'd0;
            r_valid  <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (r_cnt == 8'(SETTLE_CYCLES - 1)) begin
            r_cnt   <= 8'd0;
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_SAMPLE: begin
          for (int i = 0; i < 8; i++) begin
            r_ones[i] <= r_ones[i] + {3'b000, puf_response[i]};
          end
          if (r_cnt == 8'(NUM_SAMPLES - 1)) begin
            r_cnt   <= 8'd0;
            r_state <= S_COMMIT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_COMMIT: begin
          r_key[{r_chal, 3'b000} +: 8]  <= w_keyByte;
          r_mask[{r_chal, 3'b000} +: 8] <= w_unstableByte;
          for (int i = 0; i < 8; i++) r_ones[i] <= 4'd0;
          if (r_chal == 2'd3) begin
            r_state  <= S_DONE;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b1;
          end else begin
            r_chal  <= r_chal + 2'd1;
            r_state <= S_SETTLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign puf_enable    = r_enable;
  assign puf_challenge = r_chal;
  assign busy          = r_busy;
  assign key           = r_key;
  assign unstable_mask = r_mask;
  assign key_valid     = r_valid;
  assign key_error     = r_valid && (w_popCount > 6'(MAX_UNSTABLE));

endmodule

// File: tb/tb_puf_key_extract.sv
// Self-checking bench for puf_key_extract: a cycle-timeline model derived from
// the settle/sample/commit schedule is compared against every output each cycle,
// plus hand-computed literal keys for the directed response patterns.
module tb_puf_key_extract;

  localparam int ST  = 16;
  localparam int NS  = 7;
  localparam int MU  = 4;
  localparam int PER = ST + NS + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  puf_response;
  logic        puf_enable;
  logic [1:0]  puf_challenge;
  logic        busy;
  logic [31:0] key;
  logic [31:0] unstable_mask;
  logic        key_valid;
  logic        key_error;

  int errors = 0;
  int checks = 0;

  typedef enum {M_IDLE, M_RUN, M_DONE} mmode_t;
  mmode_t mMode = M_IDLE;
  int     mT = 0;
  int     expOnes [4][8];
  int     pattern = 0;

  always #5 clk = ~clk;

  puf_key_extract #(
    .SETTLE_CYCLES(ST),
    .NUM_SAMPLES(NS),
    .MAX_UNSTABLE(MU)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .puf_response(puf_response),
    .puf_enable(puf_enable),
    .puf_challenge(puf_challenge),
    .busy(busy),
    .key(key),
    .unstable_mask(unstable_mask),
    .key_valid(key_valid),
    .key_error(key_error)
  );

  function automatic logic [7:0] patByte(input int c, input int s);
    logic [7:0] b;
    b = 8'h00;
    case (pattern)
      0: b = 8'hA5;
      1: begin
        b = 8'h10 + 8'(c);
        b[0] = b[0] ^ s[0];
      end
      2: begin
        if (c == 0) b = (s < 3) ? 8'h3F : 8'h00;
        else        b = 8'h5A;
      end
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] expKeyByte(input int c);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = (expOnes[c][i] > NS / 2);
    return b;
  endfunction

  function automatic logic [7:0] expMaskByte(input int c);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = (expOnes[c][i] != 0) && (expOnes[c][i] != NS);
    return b;
  endfunction

  task automatic clearOnes();
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 8; i++) expOnes[c][i] = 0;
  endtask

  task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every output against what the schedule says they must be this cycle.
  task automatic checkOutput();
    logic [31:0] eKey, eMask;
    logic [1:0]  eCh;
    logic        eEn, eBusy, eValid, eErr;
    eKey = '0; eMask = '0; eCh = '0; eEn = 0; eBusy = 0; eValid = 0; eErr = 0;
    if (mMode == M_RUN) begin
      eEn   = 1;
      eBusy = 1;
      eCh   = 2'((mT - 1) / PER);
      for (int j = 0; j < 4; j++) begin
        if (mT >= PER * (j + 1) + 1) begin
          eKey[j*8 +: 8]  = expKeyByte(j);
          eMask[j*8 +: 8] = expMaskByte(j);
        end
      end
    end else if (mMode == M_DONE) begin
      for (int j = 0; j < 4; j++) begin
        eKey[j*8 +: 8]  = expKeyByte(j);
        eMask[j*8 +: 8] = expMaskByte(j);
      end
      eCh    = 2'd3;
      eValid = 1;
      eErr   = ($countones(eMask) > MU);
    end
    checkOne("puf_enable", {31'd0, puf_enable}, {31'd0, eEn});
    checkOne("puf_challenge", {30'd0, puf_challenge}, {30'd0, eCh});
    checkOne("busy", {31'd0, busy}, {31'd0, eBusy});
    checkOne("key", key, eKey);
    checkOne("unstable_mask", unstable_mask, eMask);
    checkOne("key_valid", {31'd0, key_valid}, {31'd0, eValid});
    checkOne("key_error", {31'd0, key_error}, {31'd0, eErr});
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic applyStimulus(input logic st, input logic rst);
    int p, c;
    logic [7:0] resp;
    start = st;
    reset = rst;
    resp  = 8'($urandom);
    if (mMode == M_RUN) begin
      p = (mT - 1) % PER;
      c = (mT - 1) / PER;
      if (p >= ST && p < ST + NS) begin
        resp = patByte(c, p - ST);
        if (!rst) for (int i = 0; i < 8; i++) expOnes[c][i] += int'(resp[i]);
      end
    end
    puf_response = resp;
    @(posedge clk);
    if (rst) begin
      mMode = M_IDLE; mT = 0; clearOnes();
    end else if ((mMode == M_IDLE || mMode == M_DONE) && st) begin
      mMode = M_RUN; mT = 1; clearOnes();
    end else if (mMode == M_RUN) begin
      mT++;
      if (mT == 4 * PER + 1) mMode = M_DONE;
    end
    @(negedge clk);
    checkOutput();
  endtask

  // Start an extraction and wait (bounded) for key_valid, checking latency.
  task automatic runExtraction(input int pat);
    int cyc;
    pattern = pat;
    applyStimulus(1'b1, 1'b0);
    cyc = 1;
    while (!key_valid && cyc < 200) begin
      applyStimulus(1'b0, 1'b0);
      cyc++;
    end
    checkOne("latency", 32'(cyc), 32'd97);
  endtask

  initial begin
    int validCount;
    reset = 1'b1;
    start = 1'b0;
    puf_response = 8'h00;
    clearOnes();

    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0);

    // Constant response: clean key, nothing unstable.
    runExtraction(0);
    checkOne("lit_key_a5", key, 32'hA5A5A5A5);
    checkOne("lit_mask_a5", unstable_mask, 32'h0);
    checkOne("lit_err_a5", {31'd0, key_error}, 32'd0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0);

    // Toggling bit0: one unstable bit per byte, majority depends on starting phase.
    runExtraction(1);
    checkOne("lit_key_tog", key, 32'h13121110);
    checkOne("lit_mask_tog", unstable_mask, 32'h01010101);
    checkOne("lit_err_tog", {31'd0, key_error}, 32'd0);
    applyStimulus(1'b0, 1'b0);

    // Six 3-of-7 bits on challenge 0: too many unstable bits.
    runExtraction(2);
    checkOne("lit_key_err", key, 32'h5A5A5A00);
    checkOne("lit_mask_err", unstable_mask, 32'h0000003F);
    checkOne("lit_err_err", {31'd0, key_error}, 32'd1);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0);

    // Reset in the middle of sampling challenge 2, with start also high.
    pattern = 1;
    applyStimulus(1'b1, 1'b0);
    while (mT < 67) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOne("rst_key", key, 32'h0);
    checkOne("rst_busy", {31'd0, busy}, 32'd0);
    checkOne("rst_chal", {30'd0, puf_challenge}, 32'd0);
    applyStimulus(1'b0, 1'b0);
    runExtraction(0);
    checkOne("lit_key_after_rst", key, 32'hA5A5A5A5);

    // Start held high: restart straight out of DONE, key_valid lasts one cycle.
    pattern = 0;
    validCount = 0;
    for (int k = 0; k < 130; k++) begin
      applyStimulus(1'b1, 1'b0);
      if (key_valid) validCount++;
    end
    checkOne("valid_pulse_count", 32'(validCount), 32'd1);
    while (mMode == M_RUN) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/puf_key_extract.md
PUF_KEY_EXTRACT -- requirements
Module: puf_key_extract

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16, number of cycles to wait after each challenge is applied before sampling (legal 1..255).
REQ-002 Parameter NUM_SAMPLES, default 7, number of response samples taken per challenge for the majority vote (odd, legal 3..15).
REQ-003 Parameter MAX_UNSTABLE, default 4, largest number of unstable key bits still accepted (legal 0..32).
REQ-004 Port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1, synchronous, active-high reset.
REQ-006 Port start, input, 1, request to extract a new key; sampled only in IDLE or DONE.
REQ-007 Port puf_response, input, 8, 8-bit response from the upstream PUF generator.
REQ-008 Port puf_enable, output, 1, enable to the PUF generator.
REQ-009 Port puf_challenge, output, 2, challenge to the PUF generator (its 2-bit control input).
REQ-010 Port busy, output, 1, high in SETTLE, SAMPLE and COMMIT.
REQ-011 Port key, output, 32, majority-voted key; byte c holds the result for challenge c.
REQ-012 Port unstable_mask, output, 32, set bit marks a key bit whose samples disagreed.
REQ-013 Port key_valid, output, 1, high while in DONE.
REQ-014 Port key_error, output, 1, high in DONE when popcount(unstable_mask) > MAX_UNSTABLE.

Function
REQ-015 FSM states SHALL be IDLE, SETTLE, SAMPLE, COMMIT and DONE, all registered.
REQ-016 IDLE or DONE with start=1: SHALL go to SETTLE, set challenge index c=0, set puf_enable=1, and clear key, unstable_mask, key_valid, key_error and all counters.
REQ-017 Start SHALL be ignored in SETTLE, SAMPLE and COMMIT.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to SAMPLE; puf_response is ignored during SETTLE.
REQ-019 SAMPLE SHALL last exactly NUM_SAMPLES cycles; on each cycle, per-bit 4-bit counter ones[i] += puf_response[i].
REQ-020 COMMIT SHALL last 1 cycle.
REQ-021 In COMMIT: key[8c+i] = (ones[i] > NUM_SAMPLES/2, integer division).
REQ-022 In COMMIT: unstable_mask[8c+i] = (ones[i] != 0 && ones[i] != NUM_SAMPLES).
REQ-023 In COMMIT: the ones counters SHALL be cleared.
REQ-024 COMMIT with c<3: SHALL increment c and go to SETTLE (re-settle on every challenge change).
REQ-025 COMMIT with c=3: SHALL go to DONE and deassert puf_enable.
REQ-026 puf_challenge SHALL equal c at all times and SHALL change only on the COMMIT-to-SETTLE transition (or on start/reset).
REQ-027 Latency: start accepted in cycle 0 -> key_valid first high in cycle 4*(SETTLE_CYCLES+NUM_SAMPLES+1)+1 (cycle 97 with defaults).
REQ-028 key_error SHALL be computed combinationally from unstable_mask and gated by key_valid.
REQ-029 DONE SHALL hold key, unstable_mask, key_valid and key_error stable until start or reset.
REQ-030 Words in key beyond the current challenge SHALL read 0 while busy.

Reset
REQ-031 reset=1 on a rising edge SHALL force IDLE, c=0, and clear all counters.
REQ-032 reset SHALL set every output to 0: puf_enable, puf_challenge, busy, key, unstable_mask, key_valid, key_error.
REQ-033 Reset SHALL take priority over start.
REQ-034 Reset asserted mid-operation SHALL abandon the extraction with no partial key retained.
REQ-035 IDLE with start=0 SHALL remain in IDLE with all outputs 0.

Verification
REQ-036 Defaults, constant puf_response=8'hA5 for all challenges, start pulse -> key_valid at cycle 97, key=32'hA5A5A5A5, unstable_mask=0, key_error=0.
REQ-037 Response per challenge c = 8'h10+c, bit0 toggling every sample cycle -> key=32'h13121110 with bit0 of each byte = majority (4 of 7 ones -> 1), unstable_mask=32'h01010101, key_error=0.
REQ-038 Bits 0..5 of challenge 0 each see 3 of 7 ones -> those key bits=0, six bits unstable (>4) -> key_error=1.
REQ-039 Reset asserted during SAMPLE of challenge 2 -> next cycle IDLE, all outputs 0; a later start -> full 97-cycle run with correct key.
REQ-040 Start held high throughout -> accepted only in IDLE/DONE; puf_challenge steps 0,1,2,3 only at COMMIT boundaries; key_valid is high for exactly 1 cycle before the restart clears it.
